barcode_entry_controller: RTL
=============================

// Module: barcode_entry_controller
// PURPOSE
//  Sequences barcode entry for the sale terminal. Collects four keypad digits, drives them to the
//  combinational barcode-to-product-ID lookup, samples its ProductID/valid result, then offers the
//  product to the cart/pricing stage with a req/ack handshake. Flags invalid codes, supports
//  backspace/clear and an inter-digit inactivity timeout.
// PARAMETERS
//  TIMEOUT_CYCLES  50_000_000  idle cycles between digits before a partial entry is discarded; 0 = disabled
//  ERR_CYCLES      25_000_000  cycles Error is held high after an invalid code (min 1)
// PORTS
//  clk              in   1  system clock; all state updates on posedge
//  rst              in   1  asynchronous, active-high reset
//  DigitIn          in   4  keypad digit value, sampled when DigitStrobe=1
//  DigitStrobe      in   1  one-cycle pulse: new digit available
//  Backspace        in   1  one-cycle pulse: drop last entered digit
//  Clear            in   1  one-cycle pulse: discard the entire entry
//  BarcodeDigit_3..0 out 4  each; digit regs to lookup, _3 = first entered digit (MSD)
//  LookupProductID  in   4  ProductID from lookup (combinational on BarcodeDigit_*)
//  LookupValid      in   1  lookup valid flag
//  ProductID        out  4  registered product ID; meaningful while ProductReq=1
//  ProductReq       out  1  product offer to cart stage; held until ProductAck
//  ProductAck       in   1  cart stage accepts ProductID this cycle
//  Error            out  1  invalid barcode indicator
//  DigitCount       out  3  number of digits currently entered (0..4)
//  Busy             out  1  1 in LOOKUP/REQUEST/ERROR; keypad input ignored
// BEHAVIOUR
//  Reset (async, any state): state=ENTRY, digits=0, DigitCount=0, ProductID=4'hF, ProductReq=0,
//   Error=0, Busy=0, timers=0. An in-flight request is dropped silently.
//  ENTRY: priority Clear > Backspace > DigitStrobe in the same cycle.
//   DigitStrobe with DigitIn in 1..4: shift in (_3<=_2<=_1<=_0<=DigitIn order so first digit
//   ends in _3 after 4 digits), DigitCount+1. DigitIn outside 1..4: ignored, no count change.
//   Backspace at count 0: no effect; else shift back, vacated reg=0, count-1.
//   Clear: digits=0, count=0. Timer reloads on every accepted strobe/backspace.
//   4th accepted digit at cycle N -> LOOKUP at N+1.
//   Timeout: count>0 and TIMEOUT_CYCLES idle cycles elapse -> digits/count cleared, stay ENTRY.
//  LOOKUP (exactly 1 cycle): sample LookupValid/LookupProductID.
//   valid=1 -> REQUEST, ProductID<=LookupProductID, ProductReq=1 at N+2.
//   valid=0 -> ERROR, Error=1 at N+2, ProductID stays 4'hF.
//  REQUEST: ProductReq and ProductID stable until ProductAck. ProductAck -> ENTRY next cycle,
//   ProductReq=0, ProductID=4'hF, digits/count cleared. Clear also aborts to ENTRY; if Clear and
//   ProductAck coincide, Ack wins (item counted). DigitStrobe/Backspace ignored.
//  ERROR: Error=1 for exactly ERR_CYCLES cycles, then ENTRY with digits/count cleared. Clear ends
//   ERROR early (next cycle). Keypad strobes ignored.
//  ProductAck outside REQUEST is ignored. Outputs all registered; no combinational in->out paths.
//  Timer width = $clog2(max(TIMEOUT_CYCLES,ERR_CYCLES)+1); no wrap: saturates at terminal count.
// STRUCTURE
//  Package sale_terminal_pkg: state enum localparams (ENTRY, LOOKUP, REQUEST, ERROR),
//   DIGIT_MIN=1, DIGIT_MAX=4, INVALID_PRODUCT_ID=4'hF, BARCODE_DIGITS=4.
//  One sub-module: sale_down_timer (load value, enable, done pulse), instanced once and shared by
//   timeout (ENTRY) and error hold (ERROR) since the two never run concurrently.
//  The lookup itself stays outside; this block only drives digits and samples its result.
// TESTING (bench: TIMEOUT_CYCLES=20, ERR_CYCLES=5, real lookup table attached)
//  1. Strobe 3,1,2,4 -> BarcodeDigit_3..0=3,1,2,4; ProductReq=1, ProductID=0 two cycles after
//     last strobe; hold 3 cycles, Ack -> ProductReq=0, DigitCount=0, ProductID=F next cycle.
//  2. Strobe 1,1,1,1 -> Error=1 two cycles after last strobe, exactly 5 cycles, then ENTRY,
//     count=0; strobes during ERROR ignored.
//  3. Strobe 4,1,9(ignored),3,Backspace,3,2 -> count 2,2,3,2,3,4; ProductID=1 (4132).
//  4. Strobe 2,1 then idle 20 cycles -> digits cleared, count=0; same with idle 19 -> kept.
//  5. In REQUEST, Clear and Ack same cycle -> ENTRY, Ack honoured; Clear alone -> abort, no Ack.
//  6. Assert rst mid-REQUEST and mid-entry (count=3) -> all outputs reset values immediately,
//     async; after release, 2,1,3,4 -> ProductID=6.

Source files
------------

// File: rtl/sale_terminal_pkg.sv
// Shared types and constants for the sale-terminal barcode entry path.
// Defines the controller state set, the accepted keypad digit range and the invalid product marker.
package sale_terminal_pkg;

    typedef enum logic [1:0] {
        ENTRY   = 2'd0,
        LOOKUP  = 2'd1,
        REQUEST = 2'd2,
        ERROR   = 2'd3
    } state_t;

    localparam logic [3:0] DIGIT_MIN          = 4'd1;
    localparam logic [3:0] DIGIT_MAX          = 4'd4;
    localparam logic [3:0] INVALID_PRODUCT_ID = 4'hF;
    localparam int         BARCODE_DIGITS     = 4;

    function automatic logic digit_ok(input logic [3:0] d);
        return (d >= DIGIT_MIN) && (d <= DIGIT_MAX);
    endfunction

endpackage

// File: rtl/sale_down_timer.sv
// Loadable down counter that stops at zero; done marks the last counted cycle
// (value 1 while enabled), so a load of N yields done on the Nth enabled cycle.
module sale_down_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    output logic             done
);

    logic [WIDTH-1:0] count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_value;
        end else if (enable && (count_reg != '0)) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign done = enable && !load && (count_reg == WIDTH'(1));

endmodule

// File: rtl/barcode_entry_controller.sv
// Collects four keypad digits, samples the external barcode lookup and offers the
// resulting product to the cart stage with a req/ack handshake; all outputs registered.
module barcode_entry_controller
    import sale_terminal_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50_000_000,
    parameter int ERR_CYCLES     = 25_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] DigitIn,
    input  logic       DigitStrobe,
    input  logic       Backspace,
    input  logic       Clear,
    output logic [3:0] BarcodeDigit_3,
    output logic [3:0] BarcodeDigit_2,
    output logic [3:0] BarcodeDigit_1,
    output logic [3:0] BarcodeDigit_0,
    input  logic [3:0] LookupProductID,
    input  logic       LookupValid,
    output logic [3:0] ProductID,
    output logic       ProductReq,
    input  logic       ProductAck,
    output logic       Error,
    output logic [2:0] DigitCount,
    output logic       Busy
);

    localparam int TIMER_MAX = (TIMEOUT_CYCLES > ERR_CYCLES) ? TIMEOUT_CYCLES : ERR_CYCLES;
    localparam int TIMER_W   = $clog2(TIMER_MAX + 1);

    state_t       state_reg, state_next;
    logic [3:0]   digit_reg  [BARCODE_DIGITS];
    logic [3:0]   digit_next [BARCODE_DIGITS];
    logic [3:0]   shift_in   [BARCODE_DIGITS];
    logic [3:0]   shift_back [BARCODE_DIGITS];
    logic [2:0]   count_reg, count_next;
    logic [3:0]   pid_reg, pid_next;
    logic         req_reg, err_reg, busy_reg;

    logic               timer_load;
    logic               timer_en;
    logic               timer_done;
    logic [TIMER_W-1:0] timer_value;

    // Index 0 holds the newest digit; a shift-in pushes older digits toward index 3.
    for (genvar gi = 0; gi < BARCODE_DIGITS; gi++) begin : g_shift
        if (gi == 0) begin : g_in_lo
            assign shift_in[gi] = DigitIn;
        end else begin : g_in_up
            assign shift_in[gi] = digit_reg[gi-1];
        end
        if (gi == BARCODE_DIGITS - 1) begin : g_back_hi
            assign shift_back[gi] = '0;
        end else begin : g_back_lo
            assign shift_back[gi] = digit_reg[gi+1];
        end
    end

    sale_down_timer #(
        .WIDTH(TIMER_W)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .load      (timer_load),
        .load_value(timer_value),
        .enable    (timer_en),
        .done      (timer_done)
    );

    always_comb begin
        state_next  = state_reg;
        digit_next  = digit_reg;
        count_next  = count_reg;
        pid_next    = pid_reg;
        timer_load  = 1'b0;
        timer_en    = 1'b0;
        timer_value = TIMER_W'(TIMEOUT_CYCLES);

        case (state_reg)
            ENTRY: begin
                timer_en = (count_reg != 3'd0) && (TIMEOUT_CYCLES != 0);
                if (Clear) begin
                    for (int i = 0; i < BARCODE_DIGITS; i++) digit_next[i] = '0;
                    count_next = 3'd0;
                end else if (Backspace && (count_reg != 3'd0)) begin
                    digit_next = shift_back;
                    count_next = count_reg - 3'd1;
                    timer_load = 1'b1;
                end else if (DigitStrobe && digit_ok(DigitIn)) begin
                    digit_next = shift_in;
                    count_next = count_reg + 3'd1;
                    timer_load = 1'b1;
                    if (count_reg == 3'(BARCODE_DIGITS - 1)) state_next = LOOKUP;
                end else if (timer_done) begin
                    for (int i = 0; i < BARCODE_DIGITS; i++) digit_next[i] = '0;
                    count_next = 3'd0;
                end
            end
            LOOKUP: begin
                if (LookupValid) begin
                    pid_next   = LookupProductID;
                    state_next = REQUEST;
                end else begin
                    state_next  = ERROR;
                    timer_load  = 1'b1;
                    timer_value = TIMER_W'(ERR_CYCLES);
                end
            end
            REQUEST: begin
                // Ack and Clear both return to entry; a coinciding Ack is still seen by the cart stage.
                if (ProductAck || Clear) begin
                    for (int i = 0; i < BARCODE_DIGITS; i++) digit_next[i] = '0;
                    count_next = 3'd0;
                    pid_next   = INVALID_PRODUCT_ID;
                    state_next = ENTRY;
                end
            end
            ERROR: begin
                timer_en = 1'b1;
                if (Clear || timer_done) begin
                    for (int i = 0; i < BARCODE_DIGITS; i++) digit_next[i] = '0;
                    count_next = 3'd0;
                    state_next = ENTRY;
                end
            end
            default: state_next = ENTRY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ENTRY;
            for (int i = 0; i < BARCODE_DIGITS; i++) digit_reg[i] <= '0;
            count_reg <= 3'd0;
            pid_reg   <= INVALID_PRODUCT_ID;
            req_reg   <= 1'b0;
            err_reg   <= 1'b0;
            busy_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            digit_reg <= digit_next;
            count_reg <= count_next;
            pid_reg   <= pid_next;
            req_reg   <= (state_next == REQUEST);
            err_reg   <= (state_next == ERROR);
            busy_reg  <= (state_next != ENTRY);
        end
    end

    assign BarcodeDigit_3 = digit_reg[3];
    assign BarcodeDigit_2 = digit_reg[2];
    assign BarcodeDigit_1 = digit_reg[1];
    assign BarcodeDigit_0 = digit_reg[0];
    assign ProductID      = pid_reg;
    assign ProductReq     = req_reg;
    assign Error          = err_reg;
    assign DigitCount     = count_reg;
    assign Busy           = busy_reg;

endmodule
